// File: rtl/matmul_pkg.sv
// Types and default widths shared by the matmul top level and its memory path.
package matmul_pkg;

  // Identifies which fetch path issued a memory read.
  typedef enum logic {SRC_A, SRC_B} src_t;

  localparam int DEFAULT_ADDRESS_WIDTH = 16;
  localparam int DEFAULT_DATA_WIDTH    = 256;

endpackage

// File: rtl/sync_tag_fifo.sv
// Small synchronous FIFO. The pointers carry one extra wrap bit so that full
// and empty can be told apart without a separate counter.
module sync_tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[PW-1:0]];

  // Pointer update; push ignored when full, pop ignored when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter merging the A and B fetch address streams onto one
// memory request port. The grant is held while a request is stalled, every
// issued read is tagged with its source, and returning words are routed back
// in order using those tags.
module mem_read_arbiter import matmul_pkg::*; #(
  parameter int ADDRESS_WIDTH   = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               a_req_valid,
  output logic                               a_req_ready,
  input  logic [ADDRESS_WIDTH-1:0]           a_req_addr,
  output logic                               a_rsp_valid,
  input  logic                               b_req_valid,
  output logic                               b_req_ready,
  input  logic [ADDRESS_WIDTH-1:0]           b_req_addr,
  output logic                               b_rsp_valid,
  output logic [DATA_WIDTH-1:0]              rsp_data,
  output logic                               mem_req_valid,
  input  logic                               mem_req_ready,
  output logic [ADDRESS_WIDTH-1:0]           mem_req_addr,
  input  logic                               mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]              mem_rsp_data,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               rsp_err
);

  src_t grant, last_grant, held_grant;
  logic lock;
  logic tag_full, tag_empty, tag_head;
  logic handshake, tag_pop;

  // Grant selection: a stalled request keeps its grant; otherwise the side
  // that did not win last goes first when both are asking.
  always_comb begin
    grant = SRC_A;
    if (lock)
      grant = held_grant;
    else if (a_req_valid && (!b_req_valid || last_grant == SRC_B))
      grant = SRC_A;
    else if (b_req_valid)
      grant = SRC_B;
  end

  // Full FIFO holds requests off even if a response frees a slot this cycle.
  assign mem_req_valid = (a_req_valid | b_req_valid) & ~tag_full;
  assign mem_req_addr  = (grant == SRC_A) ? a_req_addr : b_req_addr;
  assign a_req_ready   = (grant == SRC_A) & mem_req_ready & ~tag_full;
  assign b_req_ready   = (grant == SRC_B) & mem_req_ready & ~tag_full;
  assign handshake     = mem_req_valid & mem_req_ready;

  // Responses come back in issue order; the FIFO head names the owner.
  assign tag_pop     = mem_rsp_valid & ~tag_empty;
  assign a_rsp_valid = tag_pop & (tag_head == SRC_A);
  assign b_rsp_valid = tag_pop & (tag_head == SRC_B);
  assign rsp_data    = mem_rsp_data;

  sync_tag_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tags (
    .clk       (clk),
    .reset     (reset),
    .push      (handshake),
    .push_data (grant),
    .pop       (tag_pop),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (outstanding)
  );

  // Arbitration history, stall lock and sticky orphan-response flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock       <= 1'b0;
      held_grant <= SRC_A;
      last_grant <= SRC_B;
      rsp_err    <= 1'b0;
    end else begin
      lock <= mem_req_valid & ~mem_req_ready;
      if (mem_req_valid && !mem_req_ready) held_grant <= grant;
      if (handshake) last_grant <= grant;
      if (mem_rsp_valid && tag_empty) rsp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: a cycle table for arbitration and stall lock,
// then hand-written sequences for backpressure, routing, error and reset.
module tb_mem_read_arbiter;
  import matmul_pkg::*;

  localparam int AW = 16;
  localparam int DW = 256;
  localparam int MO = 8;
  localparam int CW = $clog2(MO) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req_valid, a_req_ready, a_rsp_valid;
  logic          b_req_valid, b_req_ready, b_rsp_valid;
  logic [AW-1:0] a_req_addr, b_req_addr, mem_req_addr;
  logic [DW-1:0] rsp_data, mem_rsp_data;
  logic          mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [CW-1:0] outstanding;
  logic          rsp_err;

  mem_read_arbiter #(
    .ADDRESS_WIDTH   (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .a_req_valid   (a_req_valid),
    .a_req_ready   (a_req_ready),
    .a_req_addr    (a_req_addr),
    .a_rsp_valid   (a_rsp_valid),
    .b_req_valid   (b_req_valid),
    .b_req_ready   (b_req_ready),
    .b_req_addr    (b_req_addr),
    .b_rsp_valid   (b_rsp_valid),
    .rsp_data      (rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .outstanding   (outstanding),
    .rsp_err       (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    src_t          src;
    logic [AW-1:0] addr;
  } sb_t;

  // One cycle of the arbitration table; sel: 0 = A addr, 1 = B addr, -1 = don't care.
  typedef struct {
    bit av, bv, mr;
    bit mv, ar, br;
    int sel;
  } vec_t;

  sb_t  sb[$];
  vec_t tbl[12];
  int   checks   = 0;
  int   failures = 0;
  int   exp_out  = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] addr);
    return {16{addr ^ 16'h5A3C}};
  endfunction

  // Apply inputs at the falling edge; outputs are sampled 2 ns later.
  task automatic drive(input bit av, input bit bv, input logic [AW-1:0] aa,
                       input logic [AW-1:0] ba, input bit mr, input bit rv,
                       input logic [DW-1:0] rd);
    @(negedge clk);
    a_req_valid   = av;
    b_req_valid   = bv;
    a_req_addr    = aa;
    b_req_addr    = ba;
    mem_req_ready = mr;
    mem_rsp_valid = rv;
    mem_rsp_data  = rd;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    a_req_valid = 0; b_req_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    a_req_addr = '0; b_req_addr = '0; mem_rsp_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #2;
    sb.delete();
    exp_out = 0;
  endtask

  // Single requester issue with memory ready; expects acceptance.
  task automatic issue(input src_t s, input logic [AW-1:0] addr);
    drive(s == SRC_A, s == SRC_B, addr, addr, 1'b1, 1'b0, '0);
    chk("issue_outstanding", outstanding, exp_out);
    chk("issue_mem_valid", mem_req_valid, 1'b1);
    chk("issue_ready", (s == SRC_A) ? a_req_ready : b_req_ready, 1'b1);
    chk("issue_addr", mem_req_addr, addr);
    sb.push_back('{s, addr});
    exp_out++;
  endtask

  // Return the oldest expected word and check where it is routed.
  task automatic rsp_pop();
    sb_t e;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL rsp_pop: scoreboard empty got 0 expected >0");
      return;
    end
    e = sb.pop_front();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, word_of(e.addr));
    chk("rsp_outstanding", outstanding, exp_out);
    chk("rsp_a_valid", a_rsp_valid, e.src == SRC_A);
    chk("rsp_b_valid", b_rsp_valid, e.src == SRC_B);
    chk("rsp_data", rsp_data, word_of(e.addr));
    exp_out--;
  endtask

  initial begin
    logic [AW-1:0] a_addr, b_addr;

    tbl[0]  = '{1,1,1, 1,1,0,  0};
    tbl[1]  = '{1,1,1, 1,0,1,  1};
    tbl[2]  = '{1,1,1, 1,1,0,  0};
    tbl[3]  = '{1,1,1, 1,0,1,  1};
    tbl[4]  = '{1,0,1, 1,1,0,  0};
    tbl[5]  = '{1,0,0, 1,0,0,  0};
    tbl[6]  = '{1,1,0, 1,0,0,  0};
    tbl[7]  = '{1,1,0, 1,0,0,  0};
    tbl[8]  = '{1,1,0, 1,0,0,  0};
    tbl[9]  = '{1,1,1, 1,1,0,  0};
    tbl[10] = '{1,1,1, 1,0,1,  1};
    tbl[11] = '{0,0,0, 0,0,0, -1};

    do_reset();
    chk("reset_mem_valid", mem_req_valid, 1'b0);
    chk("reset_a_ready", a_req_ready, 1'b0);
    chk("reset_b_ready", b_req_ready, 1'b0);
    chk("reset_a_rsp", a_rsp_valid, 1'b0);
    chk("reset_b_rsp", b_rsp_valid, 1'b0);
    chk("reset_outstanding", outstanding, 0);
    chk("reset_err", rsp_err, 1'b0);

    // Alternation under continuous contention, then a stalled A grant that
    // must not be stolen by B.
    a_addr = 16'h0A00;
    b_addr = 16'h0B00;
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].av, tbl[i].bv, a_addr, b_addr, tbl[i].mr, 1'b0, '0);
      chk($sformatf("tbl%0d_outstanding", i), outstanding, exp_out);
      chk($sformatf("tbl%0d_mem_valid", i), mem_req_valid, tbl[i].mv);
      chk($sformatf("tbl%0d_a_ready", i), a_req_ready, tbl[i].ar);
      chk($sformatf("tbl%0d_b_ready", i), b_req_ready, tbl[i].br);
      if (tbl[i].sel >= 0)
        chk($sformatf("tbl%0d_addr", i), mem_req_addr, (tbl[i].sel == 0) ? a_addr : b_addr);
      if (tbl[i].ar) begin sb.push_back('{SRC_A, a_addr}); a_addr++; exp_out++; end
      if (tbl[i].br) begin sb.push_back('{SRC_B, b_addr}); b_addr++; exp_out++; end
    end
    while (sb.size() > 0) rsp_pop();
    drive(0, 0, '0, '0, 0, 0, '0);
    chk("tbl_drained", outstanding, 0);

    // A-only stream into a full tag FIFO; a response in the same cycle must
    // not let the waiting request through.
    do_reset();
    for (int i = 0; i < MO; i++) issue(SRC_A, 16'h0010 + AW'(i));
    drive(1, 0, 16'h0018, '0, 1, 0, '0);
    chk("full_outstanding", outstanding, MO);
    chk("full_mem_valid", mem_req_valid, 1'b0);
    chk("full_a_ready", a_req_ready, 1'b0);
    drive(1, 0, 16'h0018, '0, 1, 1, word_of(sb[0].addr));
    chk("full_pop_mem_valid", mem_req_valid, 1'b0);
    chk("full_pop_a_ready", a_req_ready, 1'b0);
    chk("full_pop_a_rsp", a_rsp_valid, 1'b1);
    chk("full_pop_data", rsp_data, word_of(sb[0].addr));
    void'(sb.pop_front());
    exp_out--;
    issue(SRC_A, 16'h0018);
    while (sb.size() > 0) rsp_pop();

    // Mixed sources routed in issue order, then an orphan response.
    issue(SRC_B, 16'h0020);
    issue(SRC_A, 16'h0021);
    issue(SRC_B, 16'h0022);
    rsp_pop(); rsp_pop(); rsp_pop();
    drive(0, 0, '0, '0, 0, 1, {DW{1'b1}});
    chk("orphan_a_rsp", a_rsp_valid, 1'b0);
    chk("orphan_b_rsp", b_rsp_valid, 1'b0);
    chk("orphan_err_before", rsp_err, 1'b0);
    drive(0, 0, '0, '0, 0, 0, '0);
    chk("orphan_err_set", rsp_err, 1'b1);
    chk("orphan_outstanding", outstanding, 0);

    // Reset with reads in flight; A must win the first arbitration after.
    issue(SRC_A, 16'h0030);
    issue(SRC_B, 16'h0031);
    issue(SRC_B, 16'h0032);
    drive(0, 0, '0, '0, 0, 0, '0);
    chk("pre_reset_outstanding", outstanding, 3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #2;
    sb.delete();
    exp_out = 0;
    chk("midreset_outstanding", outstanding, 0);
    chk("midreset_err", rsp_err, 1'b0);
    drive(1, 1, 16'h0040, 16'h0041, 1, 0, '0);
    chk("midreset_a_ready", a_req_ready, 1'b1);
    chk("midreset_b_ready", b_req_ready, 1'b0);
    chk("midreset_addr", mem_req_addr, 16'h0040);
    drive(0, 0, '0, '0, 0, 0, '0);
    chk("midreset_outstanding_after", outstanding, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
